// File: rtl/lut_arbiter.sv
// Round-robin arbiter sharing one LUT read port; optional per-requester grant counters via LUT_ARB_STATS_EN.
// Latency: accept in cycle C, lut_a in C+1, rsp_valid/rsp_data in C+LUT_LAT+2.
// Backpressure: one-hot req_ready from the RR pointer; responses cannot be stalled.
module lut_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int LUT_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [ADDR_W-1:0]          lut_a,
    input  logic [DATA_W-1:0]          lut_qspo,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
`ifdef LUT_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]      grant_cnt,
`endif
    output logic                       busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NS = LUT_LAT + 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_id;
    logic          gnt_vld;
    logic [NS-1:0] tag_vld;
    logic [PW-1:0] tag_id [NS];

    // Scan offsets high to low so the nearest requester above ptr is the last write.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_id    = '0;
        req_ready = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                gnt_vld = 1'b1;
                gnt_id  = PW'((int'(ptr) + k) % NUM_REQ);
            end
        end
        if (rst)
            gnt_vld = 1'b0;
        if (gnt_vld)
            req_ready[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            lut_a     <= '0;
            tag_vld   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            for (int s = 0; s < NS; s++)
                tag_id[s] <= '0;
        end else begin
            tag_vld   <= {tag_vld[NS-2:0], gnt_vld};
            tag_id[0] <= gnt_id;
            for (int s = 1; s < NS; s++)
                tag_id[s] <= tag_id[s-1];
            if (gnt_vld) begin
                lut_a <= req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
                ptr   <= (gnt_id == PW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            // Last tag stage lines up with the cycle lut_qspo holds its data.
            if (tag_vld[NS-1]) begin
                rsp_valid <= NUM_REQ'(1) << tag_id[NS-1];
                rsp_data  <= lut_qspo;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

    assign busy = |tag_vld;

`ifdef LUT_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_vld && gnt_id == PW'(i) && grant_cnt[i*16 +: 16] != 16'hFFFF)
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lut_arbiter.sv
// Randomized + directed bench for lut_arbiter against a queue-based reference model.
module tb_lut_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   lut_a;
    logic [DW-1:0]   lut_qspo = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            busy;
`ifdef LUT_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    // Registered LUT model: one-cycle latency, contents ~a.
    always @(posedge clk) lut_qspo <= ~lut_a;

    lut_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LUT_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .lut_a     (lut_a),
        .lut_qspo  (lut_qspo),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
`ifdef LUT_ARB_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .busy      (busy)
    );

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } ent_t;

    ent_t          q[$];
    int            m_ptr = 0;
    logic [AW-1:0] m_lut_a = '0;
    logic [N-1:0]  m_rsp_valid = '0;
    logic [DW-1:0] m_rsp_data = '0;
    int            waitc[N];
    int            cyc = 0;
    bit            chk = 1'b0;
    int            n_tests = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_grant();
        if (rst)
            return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N])
                return (m_ptr + k) % N;
        return -1;
    endfunction

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic tick(output int g);
        logic [N-1:0] exp_rdy;
        int           worst;
        @(negedge clk);
        g = model_grant();
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        if (chk) begin
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            check("lut_a", 64'(lut_a), 64'(m_lut_a));
            check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
            check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
            check("busy", 64'(busy), 64'(q.size() != 0));
            worst = 0;
            for (int i = 0; i < N; i++) begin
                if (!rst && req_valid[i] && !req_ready[i])
                    waitc[i]++;
                else
                    waitc[i] = 0;
                if (waitc[i] > worst)
                    worst = waitc[i];
            end
            check("fair_wait_exceeded", 64'(worst >= N), 64'(0));
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ptr       = 0;
            m_lut_a     = '0;
            m_rsp_valid = '0;
            m_rsp_data  = '0;
        end else begin
            if (q.size() > 0 && q[0].due == cyc + 1) begin
                m_rsp_valid = N'(1) << q[0].id;
                m_rsp_data  = q[0].data;
                void'(q.pop_front());
            end else begin
                m_rsp_valid = '0;
            end
            if (g >= 0) begin
                m_lut_a = req_addr[g*AW +: AW];
                q.push_back('{g, ~req_addr[g*AW +: AW], cyc + 3});
                m_ptr = (g + 1) % N;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        int g;
        for (int i = 0; i < N; i++)
            waitc[i] = 0;

        rst = 1'b1;
        chk = 1'b0;
        tick(g);
        chk = 1'b1;
        tick(g);
        rst = 1'b0;

        // Single request on requester 0.
        req_addr[0 +: AW] = 8'hF0;
        req_valid = 4'b0001;
        tick(g);
        req_valid = '0;
        repeat (5) tick(g);

        // All four requesting continuously.
        req_addr  = {8'h40, 8'h30, 8'h20, 8'h10};
        req_valid = 4'hF;
        repeat (12) tick(g);
        req_valid = '0;
        repeat (4) tick(g);

        // Move ptr to 2, then requesters 3 and 1 together: 3 wins, then 1 after wrap.
        req_valid = 4'b0010;
        tick(g);
        req_valid = '0;
        tick(g);
        req_valid = 4'b1010;
        tick(g);
        req_valid[3] = 1'b0;
        tick(g);
        req_valid = '0;
        repeat (4) tick(g);

        // Reset one cycle after an accept; in-flight lookup must vanish.
        req_addr[2*AW +: AW] = 8'h55;
        req_valid = 4'b0100;
        tick(g);
        req_valid = '0;
        rst = 1'b1;
        tick(g);
        rst = 1'b0;
        req_addr[0 +: AW] = 8'hAA;
        req_valid = 4'b0001;
        tick(g);
        req_valid = '0;
        repeat (5) tick(g);

        // Idle.
        repeat (10) tick(g);

        // Random traffic; requesters hold until granted.
        for (int c = 0; c < 400; c++) begin
            tick(g);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || g == i) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_addr[i*AW +: AW] = AW'($urandom);
                end
            end
        end
        req_valid = '0;
        repeat (5) tick(g);

`ifdef LUT_ARB_STATS_EN
        rst = 1'b1;
        tick(g);
        rst = 1'b0;
        check("cnt_after_rst", grant_cnt, 64'h0);
        req_addr[AW +: AW] = 8'h3C;
        req_valid = 4'b0010;
        repeat (70000) tick(g);
        req_valid = '0;
        tick(g);
        check("cnt_saturate", grant_cnt, {16'h0, 16'h0, 16'hFFFF, 16'h0});
        rst = 1'b1;
        tick(g);
        rst = 1'b0;
        check("cnt_clear", grant_cnt, 64'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
